// File: rtl/apb_arbiter_pkg.sv
// Shared types and default parameters for the two-requester APB bridge arbiter.
package apb_arb_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_t;

endpackage

// File: rtl/apb_arbiter_if.sv
// Requester-side command/response signals plus the bridge-side command bus.
interface apb_arbiter_if
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic [1:0]                   req_i;
  logic [1:0]                   req_wr_i;
  logic [1:0][ADDR_W-1:0]       req_addr_i;
  logic [1:0][DATA_W-1:0]       req_wdata_i;
  logic [1:0][DATA_W/8-1:0]     req_strb_i;
  logic [1:0]                   gnt_o;
  logic [1:0]                   done_o;
  logic                         err_o;
  logic [DATA_W-1:0]            rdata_o;

  logic                         trnsfr;
  logic                         dsel;
  logic                         wr;
  logic [ADDR_W-1:0]            address;
  logic [DATA_W-1:0]            data_in;
  logic [DATA_W/8-1:0]          strb;
  logic [DATA_W-1:0]            data_out;
  logic                         ready;

  modport master (
    input  req_i, req_wr_i, req_addr_i, req_wdata_i, req_strb_i, data_out, ready,
    output gnt_o, done_o, err_o, rdata_o, trnsfr, dsel, wr, address, data_in, strb
  );

  modport slave (
    output req_i, req_wr_i, req_addr_i, req_wdata_i, req_strb_i, data_out, ready,
    input  gnt_o, done_o, err_o, rdata_o, trnsfr, dsel, wr, address, data_in, strb
  );

endinterface

// File: rtl/apb_arbiter_rr_pick.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the
// requester that did not win last time.
module apb_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/apb_arbiter.sv
// Round-robin arbiter sharing one APB bridge between two requesters, with a
// WAIT-state timeout that completes the transfer with an error.
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  apb_arbiter_if.master bus
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_t          state;
  arb_state_t          state_next;
  logic [1:0]          pick;
  logic [1:0]          win;
  logic                last;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic [7:0]          cnt;
  logic                timed_out;

  assign timed_out = (cnt == 8'(TIMEOUT - 1));

  apb_rr_pick u_pick (
    .req  (bus.req_i),
    .last (last),
    .win  (pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (|bus.req_i) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (bus.ready || timed_out) state_next = ST_RESP;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // The command is latched once in IDLE and held untouched until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win     <= 2'b00;
      last    <= 1'b1;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt     <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|bus.req_i) begin
            win     <= pick;
            last    <= pick[1];
            wr_q    <= bus.req_wr_i[pick[1]];
            addr_q  <= bus.req_addr_i[pick[1]];
            wdata_q <= bus.req_wdata_i[pick[1]];
            strb_q  <= bus.req_strb_i[pick[1]];
          end
        end
        ST_ISSUE: cnt <= 8'd0;
        ST_WAIT: begin
          // ready wins over the terminal count when both land together.
          if (bus.ready) begin
            rdata_q <= wr_q ? '0 : bus.data_out;
            err_q   <= 1'b0;
          end else if (timed_out) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: cnt <= 8'd0;
      endcase
    end
  end

  assign bus.gnt_o   = (state == ST_ISSUE || state == ST_WAIT) ? win : 2'b00;
  assign bus.done_o  = (state == ST_RESP) ? win : 2'b00;
  assign bus.err_o   = (state == ST_RESP) && err_q;
  assign bus.rdata_o = rdata_q;
  assign bus.trnsfr  = (state == ST_ISSUE);
  assign bus.dsel    = (state == ST_ISSUE || state == ST_WAIT);
  assign bus.wr      = wr_q;
  assign bus.address = addr_q;
  assign bus.data_in = wdata_q;
  assign bus.strb    = strb_q;

endmodule
